uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_bit_timer.sv | 34 +++
 rtl/uart_rx.sv | 112 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and framing constants
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 217;
  localparam int DATA_BITS            = 8;

  // Counter must hold CLKS_PER_BIT-1; keep at least 8 bits.
  function automatic int cnt_width(input int clks);
    return ($clog2(clks) < 8) ? 8 : $clog2(clks);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period counter with half and terminal count flags
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tc,
  output logic half
);

  localparam int W = cnt_width(CLKS_PER_BIT);
  localparam logic [W-1:0] TC_VAL   = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] HALF_VAL = W'(CLKS_PER_BIT / 2 - 1);

  logic [W-1:0] count;

  // Saturates at terminal count so an uncleared counter can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != TC_VAL) begin
      count <= count + W'(1);
    end
  end

  assign tc   = (count == TC_VAL);
  assign half = (count == HALF_VAL);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver: synchronizer, framing FSM and shift register
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rx_s;
  uart_state_e          state;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 timer_clear;
  logic                 tc;
  logic                 half;

  // Flops reset high so a released reset never looks like a start edge.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_comb begin
    timer_clear = 1'b0;
    case (state)
      ST_IDLE:  timer_clear = 1'b1;
      ST_START: timer_clear = half;
      ST_DATA:  timer_clear = tc;
      ST_STOP:  timer_clear = tc;
      default:  timer_clear = 1'b1;
    endcase
  end

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (CLOCK_50),
    .rst_n(reset_n),
    .clear(timer_clear),
    .tc   (tc),
    .half (half)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      bit_idx      <= '0;
      shift_reg    <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          bit_idx <= '0;
          if (!rx_s) state <= ST_START;
        end
        ST_START: begin
          // A high line at mid start bit is a glitch, not a frame.
          if (half) begin
            if (!rx_s) begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (tc) begin
            shift_reg[bit_idx] <= rx_s;
            if (bit_idx == LAST_IDX) state <= ST_STOP;
            else bit_idx <= bit_idx + IW'(1);
          end
        end
        ST_STOP: begin
          if (tc) begin
            state <= ST_IDLE;
            if (rx_s) begin
              rx_data  <= shift_reg;
              rx_valid <= 1'b1;
            end else begin
              rx_frame_err <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rx_busy = (state != ST_IDLE);

endmodule
